// File: rtl/pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_seq
// Purpose  : Retunes one PLL output counter via the pll_reconfig Avalon-MM
//            port, then waits for a stable lock. Optional lock timeout is
//            enabled by defining PLL_SEQ_LOCK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_seq #(
   parameter int unsigned C_SEL       = 5,
   parameter int unsigned DIV0        = 447,
   parameter int unsigned DIV1        = 224,
   parameter int unsigned DIV2        = 112,
   parameter int unsigned DIV3        = 56,
   parameter int unsigned INIT_SEL    = 0,
   parameter int unsigned LOCK_STABLE = 16,
   parameter int unsigned TIMEOUT     = 65535
) (
   input  logic        refclk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [1:0]  req_sel,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  cur_sel,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_write,
   output logic        mgmt_read,
   output logic [31:0] mgmt_writedata,
   input  logic [31:0] mgmt_readdata,
   input  logic        mgmt_waitrequest,
   input  logic        pll_locked
);

   localparam logic [5:0]  c_addr_mode   = 6'd0;
   localparam logic [5:0]  c_addr_status = 6'd1;
   localparam logic [5:0]  c_addr_start  = 6'd2;
   localparam logic [5:0]  c_addr_c      = 6'd5;
   localparam logic [4:0]  c_c_sel       = 5'(C_SEL);
   localparam logic [15:0] c_stable_last = 16'(LOCK_STABLE - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_MODE   = 3'd1,
      S_WR_C      = 3'd2,
      S_WR_START  = 3'd3,
      S_STATUS_RD = 3'd4,
      S_WAIT_LOCK = 3'd5
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_sel;
   logic [1:0]  r_cur_sel;
   logic        r_done;
   logic [15:0] r_stable;
   logic        w_accept, w_same, w_finish, w_abort;
   logic [8:0]  w_div;
   logic [7:0]  w_hi, w_lo;
   logic        w_unused_rd;

   assign w_unused_rd = ^mgmt_readdata[31:1];

   always_comb begin
      case (r_sel)
         2'd0:    w_div = 9'(DIV0);
         2'd1:    w_div = 9'(DIV1);
         2'd2:    w_div = 9'(DIV2);
         default: w_div = 9'(DIV3);
      endcase
   end

   // hi gets the extra VCO cycle when the divisor is odd
   assign w_lo = w_div[8:1];
   assign w_hi = w_div[8:1] + {7'd0, w_div[0]};

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
   localparam logic [15:0] c_to_last = 16'(TIMEOUT - 1);
   logic [15:0] r_to;
   logic        r_err;
   logic        w_timeout;

   assign w_timeout = ((r_state == S_STATUS_RD) || (r_state == S_WAIT_LOCK))
                      && (r_to == c_to_last);
   assign err = r_err;

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         r_to  <= 16'd0;
         r_err <= 1'b0;
      end else begin
         // zero throughout the write phase, so it starts at 0 in STATUS_RD
         if ((r_state == S_STATUS_RD) || (r_state == S_WAIT_LOCK))
            r_to <= r_to + 16'd1;
         else
            r_to <= 16'd0;
         if (w_accept)
            r_err <= 1'b0;
         else if (w_abort)
            r_err <= 1'b1;
      end
   end
`else
   logic [15:0] w_unused_to;
   assign w_unused_to = 16'(TIMEOUT);
   assign err = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_accept       = 1'b0;
      w_same         = 1'b0;
      w_finish       = 1'b0;
      w_abort        = 1'b0;
      mgmt_write     = 1'b0;
      mgmt_read      = 1'b0;
      mgmt_address   = 6'd0;
      mgmt_writedata = 32'd0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               if (req_sel != r_cur_sel) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_WR_MODE;
               end else begin
                  w_same = 1'b1;
               end
            end
         end
         S_WR_MODE: begin
            mgmt_write   = 1'b1;
            mgmt_address = c_addr_mode;
            if (!mgmt_waitrequest) w_state_nxt = S_WR_C;
         end
         S_WR_C: begin
            mgmt_write     = 1'b1;
            mgmt_address   = c_addr_c;
            mgmt_writedata = {9'd0, c_c_sel, w_div[0], 1'b0, w_hi, w_lo};
            if (!mgmt_waitrequest) w_state_nxt = S_WR_START;
         end
         S_WR_START: begin
            mgmt_write   = 1'b1;
            mgmt_address = c_addr_start;
            if (!mgmt_waitrequest) w_state_nxt = S_STATUS_RD;
         end
         S_STATUS_RD: begin
            mgmt_read    = 1'b1;
            mgmt_address = c_addr_status;
            if (!mgmt_waitrequest && mgmt_readdata[0]) w_state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (pll_locked && (r_stable == c_stable_last)) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
      if (w_timeout) begin
         w_finish    = 1'b0;
         w_abort     = 1'b1;
         w_state_nxt = S_IDLE;
      end
`endif
   end

   always_ff @(posedge refclk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_sel     <= 2'(INIT_SEL);
         r_cur_sel <= 2'(INIT_SEL);
         r_done    <= 1'b0;
         r_stable  <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_finish | w_same | w_abort;
         if (w_accept) r_sel <= req_sel;
         if (w_finish) r_cur_sel <= r_sel;
         if ((r_state == S_WAIT_LOCK) && pll_locked)
            r_stable <= r_stable + 16'd1;
         else
            r_stable <= 16'd0;
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign done    = r_done;
   assign cur_sel = r_cur_sel;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reconfig_seq
// Purpose  : Randomized self-checking bench for pll_reconfig_seq against a
//            cycle-trace reference built from the bus/lock rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_seq;
   localparam int unsigned C_SEL       = 5;
   localparam int unsigned DIV0        = 447;
   localparam int unsigned DIV1        = 224;
   localparam int unsigned DIV2        = 112;
   localparam int unsigned DIV3        = 56;
   localparam int unsigned INIT_SEL    = 0;
   localparam int unsigned LOCK_STABLE = 16;
   localparam int unsigned TIMEOUT     = 100;

   logic        refclk = 1'b0;
   logic        rst_n, req, mgmt_waitrequest, pll_locked;
   logic [1:0]  req_sel;
   logic [31:0] mgmt_readdata;
   logic        busy, done, err, mgmt_write, mgmt_read;
   logic [1:0]  cur_sel;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;

   pll_reconfig_seq #(
      .C_SEL(C_SEL), .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3),
      .INIT_SEL(INIT_SEL), .LOCK_STABLE(LOCK_STABLE), .TIMEOUT(TIMEOUT)
   ) dut (
      .refclk(refclk), .rst_n(rst_n), .req(req), .req_sel(req_sel),
      .busy(busy), .done(done), .err(err), .cur_sel(cur_sel),
      .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
      .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
      .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
   );

   always #10 refclk = ~refclk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [5:0]  addr;
      logic [31:0] data;
      logic        wreq;
      logic        rbit;
      logic        lk;
   } cyc_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic [1:0] m_cur;
   logic       m_err;
   cyc_t trace[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned div_of(input logic [1:0] s);
      case (s)
         2'd0:    return DIV0;
         2'd1:    return DIV1;
         2'd2:    return DIV2;
         default: return DIV3;
      endcase
   endfunction

   // C counter word from plain arithmetic: C index, odd, hi = ceil(D/2), lo = floor(D/2)
   function automatic logic [31:0] c_word(input logic [1:0] s);
      int unsigned d;
      d = div_of(s);
      return 32'(C_SEL * 262144 + (d % 2) * 131072 + ((d + 1) / 2) * 256 + d / 2);
   endfunction

   task automatic check_cycle(input string tag, input logic e_busy, input logic e_done,
                              input logic e_wr, input logic e_rd, input logic [5:0] e_addr,
                              input logic [31:0] e_data);
      check({tag, ".ctl"}, {58'd0, busy, done, mgmt_write, mgmt_read, err, cur_sel},
            {58'd0, e_busy, e_done, e_wr, e_rd, m_err, m_cur});
      if (e_wr || e_rd) check({tag, ".addr"}, {58'd0, mgmt_address}, {58'd0, e_addr});
      if (e_wr) check({tag, ".wdata"}, {32'd0, mgmt_writedata}, {32'd0, e_data});
   endtask

   task automatic check_reset_outputs(input string tag);
      check(tag, {19'd0, busy, done, err, cur_sel, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata},
            {19'd0, 1'b0, 1'b0, 1'b0, 2'(INIT_SEL), 1'b0, 1'b0, 6'd0, 32'd0});
   endtask

   task automatic push_write(input logic [5:0] a, input logic [31:0] d, input int stall);
      cyc_t c;
      for (int i = 0; i <= stall; i++) begin
         c.wr = 1'b1; c.rd = 1'b0; c.addr = a; c.data = d;
         c.wreq = (i < stall); c.rbit = 1'($urandom); c.lk = 1'($urandom);
         trace.push_back(c);
      end
   endtask

   // One request; the expected trace is built first, then replayed cycle by cycle.
   task automatic run_txn(input logic [1:0] sel, input int s0, input int s1, input int s2,
                          input int nret, input int sr, input int p, input int g,
                          input bit to_test);
      cyc_t c;
      int   cnt, k;
      logic lk;
      logic [31:0] rd;
      trace.delete();
      @(posedge refclk); #1;
      req = 1'b1; req_sel = sel;
      mgmt_waitrequest = 1'($urandom); pll_locked = 1'($urandom);
      @(negedge refclk);
      check_cycle("req", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
      if (sel == m_cur) begin
         @(posedge refclk); #1; req = 1'b0;
         @(negedge refclk);
         check_cycle("same", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
         @(posedge refclk); #1;
         @(negedge refclk);
         check_cycle("same_after", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
         return;
      end
      m_err = 1'b0;
      push_write(6'd0, 32'd0, s0);
      push_write(6'd5, c_word(sel), s1);
      push_write(6'd2, 32'd0, s2);
      for (int r = 0; r <= nret; r++) begin
         for (int i = 0; i <= sr; i++) begin
            c.wr = 1'b0; c.rd = 1'b1; c.addr = 6'd1; c.data = 32'd0;
            c.wreq = (i < sr);
            c.rbit = c.wreq ? 1'($urandom) : (r == nret);
            c.lk = 1'($urandom);
            trace.push_back(c);
         end
      end
      if (to_test) begin
         // 100 cycles from first STATUS_RD cycle: one read cycle, then 99 unlocked
         for (int i = 0; i < int'(TIMEOUT) - 1 - nret - sr; i++) begin
            c.wr = 1'b0; c.rd = 1'b0; c.addr = 6'd0; c.data = 32'd0;
            c.wreq = 1'($urandom); c.rbit = 1'($urandom); c.lk = 1'b0;
            trace.push_back(c);
         end
      end else begin
         cnt = 0; k = 0;
         while (cnt < int'(LOCK_STABLE)) begin
            if (k < p)                  lk = 1'b0;
            else if (k < p + g)         lk = 1'b1;
            else if (g > 0 && k == p + g) lk = 1'b0;
            else                        lk = 1'b1;
            cnt = lk ? cnt + 1 : 0;
            c.wr = 1'b0; c.rd = 1'b0; c.addr = 6'd0; c.data = 32'd0;
            c.wreq = 1'($urandom); c.rbit = 1'($urandom); c.lk = lk;
            trace.push_back(c);
            k++;
         end
      end
      foreach (trace[i]) begin
         @(posedge refclk); #1;
         mgmt_waitrequest = trace[i].wreq;
         rd = $urandom; rd[0] = trace[i].rbit;
         mgmt_readdata = rd;
         pll_locked = trace[i].lk;
         req = 1'($urandom); req_sel = 2'($urandom);
         @(negedge refclk);
         check_cycle($sformatf("cyc%0d", i), 1'b1, 1'b0, trace[i].wr, trace[i].rd,
                     trace[i].addr, trace[i].data);
      end
      @(posedge refclk); #1;
      req = 1'b0;
      if (to_test) m_err = 1'b1;
      else         m_cur = sel;
      @(negedge refclk);
      check_cycle("done", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0);
      @(posedge refclk); #1;
      @(negedge refclk);
      check_cycle("done_after", 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0);
   endtask

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req = 1'b0; req_sel = 2'd0;
      mgmt_waitrequest = 1'b0; mgmt_readdata = 32'd0; pll_locked = 1'b0;
      m_cur = 2'(INIT_SEL); m_err = 1'b0;
      repeat (3) @(posedge refclk);
      @(negedge refclk);
      check_reset_outputs("reset");
      @(posedge refclk); #1; rst_n = 1'b1;

      run_txn(2'd2, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      run_txn(2'd0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      run_txn(2'd0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
      run_txn(2'd1, 0, 5, 0, 0, 0, 0, 10, 1'b0);
      run_txn(2'd3, 2, 1, 3, 2, 2, 3, 0, 1'b0);

      // abort in WR_START
      @(posedge refclk); #1;
      req = 1'b1; req_sel = m_cur ^ 2'd1; mgmt_waitrequest = 1'b0;
      @(posedge refclk); #1; req = 1'b0;
      @(posedge refclk); #1;
      @(posedge refclk); #1; mgmt_waitrequest = 1'b1; rst_n = 1'b0;
      @(negedge refclk);
      check("rst_wr_start", {56'd0, mgmt_write, mgmt_read, mgmt_address},
            {56'd0, 1'b1, 1'b0, 6'd2});
      @(posedge refclk); #1; rst_n = 1'b1; mgmt_waitrequest = 1'b0;
      @(negedge refclk);
      check_reset_outputs("rst_abort");
      m_cur = 2'(INIT_SEL); m_err = 1'b0;
      run_txn(2'd3, 0, 0, 0, 0, 0, 0, 0, 1'b0);

`ifdef PLL_SEQ_LOCK_TIMEOUT_EN
      run_txn(m_cur ^ 2'd2, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      run_txn(m_cur ^ 2'd1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
`endif

      for (int t = 0; t < 30; t++) begin
         run_txn(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Sequencer that retunes one output counter of the system's reconfigurable PLL at run time. It selects one of four divisor profiles, for example turbo CPU clock rates. It sits between core control logic and the Altera `pll_reconfig` management port. It issues the Avalon-MM write/read sequence (mode, C counter, start, status) and then qualifies `locked` before reporting completion. It runs on the PLL reference clock domain (50 MHz).

## Interface
Parameters:
- `C_SEL`, 5: PLL output counter index to retune (0–17).
- `DIV0`, 447: VCO divisor for profile 0 (legal 2–510).
- `DIV1`, 224: VCO divisor for profile 1.
- `DIV2`, 112: VCO divisor for profile 2.
- `DIV3`, 56: VCO divisor for profile 3.
- `INIT_SEL`, 0: profile the PLL is compiled with; the reset value of `cur_sel`.
- `LOCK_STABLE`, 16: consecutive `locked`=1 cycles required to finish.
- `TIMEOUT`, 65535: cycle limit for the STATUS_RD plus WAIT_LOCK phases; used only with `PLL_SEQ_LOCK_TIMEOUT_EN`.

Ports:
- `refclk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in 1: request; sampled only while `busy`=0.
- `req_sel` in 2: requested profile.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky timeout flag.
- `cur_sel` out 2: profile currently programmed.
- `mgmt_address` out 6: reconfig register address.
- `mgmt_write` out 1: Avalon write strobe.
- `mgmt_read` out 1: Avalon read strobe.
- `mgmt_writedata` out 32: write data.
- `mgmt_readdata` in 32: read data (ignored except in STATUS_RD).
- `mgmt_waitrequest` in 1: Avalon stall.
- `pll_locked` in 1: PLL lock, already synchronised to `refclk`.

## Operation
- States: IDLE, WR_MODE, WR_C, WR_START, STATUS_RD, WAIT_LOCK.
- **IDLE**:
  - `req`=1 with `req_sel`≠`cur_sel` → WR_MODE. `busy`=1 next cycle and `err` clears.
  - `req`=1 with `req_sel`=`cur_sel` → no bus traffic. `done` pulses next cycle and `busy` stays 0.
- **Write states**: hold `mgmt_write`=1 and stable address/data until a cycle with `mgmt_waitrequest`=0. The write completes on that edge and the FSM advances.
  - WR_MODE: address 0, data 0 (waitrequest mode).
  - WR_C: address 5, data = {9'b0, `C_SEL`[4:0], odd, bypass=0, hi[7:0], lo[7:0]}.
    - hi = ceil(D/2), lo = floor(D/2), odd = D[0], where D is the divisor of the latched profile.
  - WR_START: address 2, data 0.
- **STATUS_RD**: `mgmt_read`=1 at address 1 until `mgmt_waitrequest`=0.
  - If `mgmt_readdata`[0]=1 → WAIT_LOCK.
  - Otherwise reissue the read next cycle.
- **WAIT_LOCK**: the stable counter increments while `pll_locked`=1 and resets to 0 when `pll_locked`=0. Reaching `LOCK_STABLE` → IDLE.
  - At that edge: `cur_sel` ← latched sel, `done` pulses, `busy`→0.
- `req_sel` is latched at acceptance. Changes to `req`/`req_sel` while busy are ignored and are not queued.
- `mgmt_read` and `mgmt_write` are never both 1.
- Reset (any state, including mid-transaction) → IDLE on the next edge. The abort is legal because the reconfig IP shares `rst_n`.
  - Outputs after reset: `busy`=0, `done`=0, `err`=0, `cur_sel`=`INIT_SEL`, `mgmt_write`=0, `mgmt_read`=0, `mgmt_address`=0, `mgmt_writedata`=0.

## Timing
- Request accepted at edge T: `mgmt_write`=1 with address 0 from T+1.
- With `mgmt_waitrequest` held at 0:
  - address 5 at T+2, address 2 at T+3, read at T+4.
  - WAIT_LOCK from T+5 if status bit0=1.
- `done` is asserted for exactly one cycle, on the same edge that `busy` falls.
- Same-profile request: `done` at T+1, `busy` never asserts.
- Divisor arithmetic uses 9-bit unsigned; D outside 2–510 is a configuration error and is not checked.

## Configuration
- **`PLL_SEQ_LOCK_TIMEOUT_EN` defined**:
  - A 16-bit counter clears on entry to STATUS_RD and counts every cycle in STATUS_RD and WAIT_LOCK.
  - Reaching `TIMEOUT` → IDLE with `err`=1, `done` pulse, `cur_sel` unchanged.
  - A pending read is dropped (`mgmt_read`→0).
- **Undefined**: no counter. The FSM waits indefinitely, `err` is tied 0, and `TIMEOUT` is unused.

## Test plan
- Reset, then `req`=1 with `req_sel`=2, waitrequest=0, status=1, locked=1 → writes (0,0), (5,0x0014_3838), (2,0); read at address 1; `done` at T+5+16; `cur_sel`=2.
- `req_sel`=0 (DIV0=447) → C data = 0x0016_E0DF (odd=1, hi=224, lo=223).
- `req_sel`=`cur_sel` → no `mgmt_write`/`mgmt_read`, `done` at T+1, `busy` stays 0.
- Waitrequest=1 for 5 cycles during WR_C; `pll_locked` glitches low at stable count 10 → address/data held for 6 cycles; stable count restarts; `done` 16 cycles after locked is last seen rising.
- `rst_n`=0 during WR_START → next cycle IDLE, all outputs at reset values; a new `req` then succeeds.
- With `PLL_SEQ_LOCK_TIMEOUT_EN`, `TIMEOUT`=100, locked held 0 → `err`=1 and `done` 100 cycles after STATUS_RD entry; `cur_sel` unchanged; the next accepted `req` clears `err`.
